// File: rtl/spc_config_deserializer.sv
// Serial configuration deserializer: oversamples Cfg_clk/Cfg_in/Cfg_en in the Clk domain,
// shifts bits LSB-first and commits a WIDTH-bit word only when a frame is complete.
module spc_config_deserializer #(
    parameter int               WIDTH       = 11,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_WORD  = '0
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Cfg_clk,
    input  logic             Cfg_in,
    input  logic             Cfg_en,
    output logic [WIDTH-1:0] Cfg_word,
    output logic             Cfg_valid,
    output logic             Cfg_busy,
    output logic             Cfg_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] in_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   sync_clk_d;
    logic                   sync_clk;
    logic                   sync_in;
    logic                   sync_en;
    logic                   rise;

    state_t                 state;
    logic [WIDTH-1:0]       shreg;
    logic [CW-1:0]          count;

    // Equal-depth chains keep data and enable aligned with the clock they belong to.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            clk_sync   <= '0;
            in_sync    <= '0;
            en_sync    <= '0;
            sync_clk_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each stage sample the previous stage's old value.
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], Cfg_clk};
            in_sync    <= {in_sync[SYNC_STAGES-2:0], Cfg_in};
            en_sync    <= {en_sync[SYNC_STAGES-2:0], Cfg_en};
            sync_clk_d <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sync_clk = clk_sync[SYNC_STAGES-1];
    assign sync_in  = in_sync[SYNC_STAGES-1];
    assign sync_en  = en_sync[SYNC_STAGES-1];
    assign rise     = sync_clk & ~sync_clk_d;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            Cfg_word  <= RESET_WORD;
            Cfg_valid <= 1'b0;
            Cfg_busy  <= 1'b0;
            Cfg_err   <= 1'b0;
        end else begin
            Cfg_valid <= 1'b0;
            Cfg_err   <= 1'b0;
            case (state)
                IDLE: begin
                    count    <= '0;
                    shreg    <= '0;
                    Cfg_busy <= 1'b0;
                    if (sync_en) state <= SHIFT;
                end
                SHIFT: begin
                    // An enable drop outranks a coincident rise, so that bit is discarded.
                    if (!sync_en) begin
                        Cfg_err  <= (count != '0);
                        count    <= '0;
                        shreg    <= '0;
                        Cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (rise) begin
                        shreg <= {sync_in, shreg[WIDTH-1:1]};
                        count <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) begin
                            Cfg_busy <= 1'b0;
                            state    <= COMMIT;
                        end else begin
                            Cfg_busy <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    Cfg_word  <= shreg;
                    Cfg_valid <= 1'b1;
                    count     <= '0;
                    Cfg_busy  <= 1'b0;
                    state     <= sync_en ? SHIFT : IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spc_config_deserializer.sv
// Scoreboard bench for spc_config_deserializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every Cfg_valid pulse.
module tb_spc_config_deserializer;

    localparam int WIDTH = 11;
    localparam int HALF  = 50;  // 50 MHz Clk, 500 kHz Cfg_clk

    logic             clk;
    logic             rst_n;
    logic             cfg_clk;
    logic             cfg_in;
    logic             cfg_en;
    logic [WIDTH-1:0] cfg_word;
    logic             cfg_valid;
    logic             cfg_busy;
    logic             cfg_err;

    int checks    = 0;
    int failures  = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    int valid_exp  = 0;
    int err_exp    = 0;
    logic [WIDTH-1:0] exp_word = '0;
    logic [WIDTH-1:0] exp_q[$];

    spc_config_deserializer #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .RESET_WORD (11'h000)
    ) dut (
        .Clk      (clk),
        .Resetn   (rst_n),
        .Cfg_clk  (cfg_clk),
        .Cfg_in   (cfg_in),
        .Cfg_en   (cfg_en),
        .Cfg_word (cfg_word),
        .Cfg_valid(cfg_valid),
        .Cfg_busy (cfg_busy),
        .Cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every Cfg_valid pulse must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (cfg_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(cfg_word), 32'hFFFF_FFFF);
            end else begin
                check("word_on_valid", 32'(cfg_word), 32'(exp_q.pop_front()));
            end
        end
        if (cfg_err) err_seen++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b, input bit chk_busy, input logic busy_req);
        wait_cycles(1);
        cfg_clk = 1'b0;
        cfg_in  = b;
        wait_cycles(HALF);
        cfg_clk = 1'b1;
        wait_cycles(10);
        if (chk_busy) check("busy_in_frame", 32'(cfg_busy), 32'(busy_req));
        wait_cycles(HALF - 10);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input bit chk_busy);
        for (int i = 0; i < nbits; i++) drive_bit(w[i], chk_busy, (i + 1 < WIDTH));
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit chk_busy);
        exp_q.push_back(w);
        valid_exp++;
        exp_word = w;
        send_bits(w, WIDTH, chk_busy);
    endtask

    initial begin
        rst_n   = 1'b0;
        cfg_clk = 1'b0;
        cfg_in  = 1'b0;
        cfg_en  = 1'b0;
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(30);

        // Reset and idle
        check("reset_word", 32'(cfg_word), 32'h000);
        check("reset_busy", 32'(cfg_busy), 32'h0);
        check("reset_valid_cnt", 32'(valid_seen), 32'h0);
        check("reset_err_cnt", 32'(err_seen), 32'h0);

        // Single frame with busy tracking
        cfg_en = 1'b1;
        wait_cycles(10);
        check("busy_before_frame", 32'(cfg_busy), 32'h0);
        send_word(11'h561, 1'b1);
        check("word_0x561", 32'(cfg_word), 32'h561);
        check("valid_cnt_1", 32'(valid_seen), 32'(valid_exp));

        // Back-to-back frames, enable held high
        send_word(11'h561, 1'b0);
        check("b2b_first", 32'(cfg_word), 32'h561);
        send_word(11'h657, 1'b0);
        check("b2b_second", 32'(cfg_word), 32'h657);
        check("valid_cnt_b2b", 32'(valid_seen), 32'(valid_exp));

        // Aborted partial frame keeps the committed word
        send_word(11'h561, 1'b0);
        send_bits(11'h657, 5, 1'b0);
        wait_cycles(1);
        cfg_clk = 1'b0;
        cfg_en  = 1'b0;
        err_exp++;
        wait_cycles(HALF);
        check("abort_err_cnt", 32'(err_seen), 32'(err_exp));
        check("abort_word_held", 32'(cfg_word), 32'h561);
        check("abort_busy", 32'(cfg_busy), 32'h0);
        cfg_en = 1'b1;
        send_word(11'h657, 1'b0);
        check("after_abort_word", 32'(cfg_word), 32'h657);

        // Clock pulses with enable low are ignored
        wait_cycles(1);
        cfg_en = 1'b0;
        wait_cycles(10);
        send_bits(11'h7FF, WIDTH, 1'b0);
        check("idle_word_held", 32'(cfg_word), 32'h657);
        check("idle_valid_cnt", 32'(valid_seen), 32'(valid_exp));
        check("idle_err_cnt", 32'(err_seen), 32'(err_exp));

        // Reset mid-frame discards bits silently
        cfg_en = 1'b1;
        send_bits(11'h561, 7, 1'b0);
        rst_n   = 1'b0;
        cfg_en  = 1'b0;
        cfg_clk = 1'b0;
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(10);
        exp_word = 11'h000;
        check("midreset_word", 32'(cfg_word), 32'(exp_word));
        check("midreset_err_cnt", 32'(err_seen), 32'(err_exp));
        check("midreset_busy", 32'(cfg_busy), 32'h0);
        cfg_en = 1'b1;
        send_word(11'h561, 1'b0);
        check("post_reset_word", 32'(cfg_word), 32'h561);

        // Enable drops on the same detected edge as the final bit
        send_bits(11'h657, WIDTH - 1, 1'b0);
        wait_cycles(1);
        cfg_clk = 1'b0;
        cfg_in  = 1'b1;
        wait_cycles(HALF);
        cfg_clk = 1'b1;
        cfg_en  = 1'b0;
        err_exp++;
        wait_cycles(HALF);
        check("late_abort_err_cnt", 32'(err_seen), 32'(err_exp));
        check("late_abort_word", 32'(cfg_word), 32'h561);
        check("late_abort_valid_cnt", 32'(valid_seen), 32'(valid_exp));

        wait_cycles(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("final_valid_cnt", 32'(valid_seen), 32'(valid_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
